// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared state encoding and parameter limits for the SRAM port arbiter
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_WAIT = 2'd1,
    WRITE_ACK = 2'd2
  } sram_arb_state_t;

  localparam int SRAM_ARB_DELAY_MIN = 1;
  localparam int SRAM_ARB_DELAY_MAX = 15;
  localparam int SRAM_ARB_CNT_W     = 4;
  localparam int SRAM_ARB_NREQ_MIN  = 2;
  localparam int SRAM_ARB_NREQ_MAX  = 4;

endpackage

// File: rtl/sram_arb_picker.sv
// rtl/sram_arb_picker.sv - one-hot winner select, searching upward from ptr and wrapping
module sram_arb_picker #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant
);

  int   idx;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - single-outstanding SRAM port arbiter for NREQ requesters
// SRAM_ARB_RR_EN selects round-robin arbitration; otherwise fixed priority (requester 0 highest).
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int WIDTH           = 16,
  parameter int LOG_DEPTH       = 9,
  parameter int LOG_LINE_OFFSET = 3,
  parameter int NREQ            = 2,
  parameter int DELAY           = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NREQ-1:0]              req_valid,
  output logic [NREQ-1:0]              req_ready,
  input  logic [NREQ-1:0]              req_write,
  input  logic [NREQ*LOG_DEPTH-1:0]    req_addr,
  input  logic [NREQ*LOG_LINE_OFFSET-1:0] req_offset,
  input  logic [NREQ*WIDTH-1:0]        req_wdata,
  output logic [NREQ-1:0]              rsp_valid,
  output logic [WIDTH-1:0]             rsp_data,
  output logic [LOG_DEPTH-1:0]         sram_read_addr,
  output logic [LOG_DEPTH-1:0]         sram_write_addr,
  output logic [LOG_LINE_OFFSET-1:0]   sram_write_offset,
  output logic [WIDTH-1:0]             sram_write_data,
  output logic                         sram_write_en,
  input  logic [WIDTH-1:0]             sram_read_data
);

  localparam int IDX_W = (NREQ > 2) ? 2 : 1;

  if (DELAY < SRAM_ARB_DELAY_MIN || DELAY > SRAM_ARB_DELAY_MAX) begin : g_bad_delay
    $error("sram_port_arbiter: DELAY out of range");
  end
  if (NREQ < SRAM_ARB_NREQ_MIN || NREQ > SRAM_ARB_NREQ_MAX) begin : g_bad_nreq
    $error("sram_port_arbiter: NREQ out of range");
  end

  sram_arb_state_t             state;
  logic [SRAM_ARB_CNT_W-1:0]   cnt;
  logic [NREQ-1:0]             owner;
  logic [IDX_W-1:0]            ptr;
  logic [LOG_DEPTH-1:0]        rd_addr_q;
  logic [LOG_DEPTH-1:0]        wr_addr_q;
  logic [LOG_LINE_OFFSET-1:0]  wr_off_q;
  logic [WIDTH-1:0]            wr_data_q;
  logic                        we_q;
  logic [NREQ-1:0]             rv_q;

  logic [NREQ-1:0]             pick_req;
  logic [NREQ-1:0]             grant;
  logic                        sel_write;
  logic [LOG_DEPTH-1:0]        sel_addr;
  logic [LOG_LINE_OFFSET-1:0]  sel_off;
  logic [WIDTH-1:0]            sel_wdata;

  // Only an idle, out-of-reset arbiter may offer a grant.
  assign pick_req = (state == IDLE && !reset) ? req_valid : '0;

  sram_arb_picker #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req   (pick_req),
    .ptr   (ptr),
    .grant (grant)
  );

  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_off   = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[i*LOG_DEPTH +: LOG_DEPTH];
        sel_off   = req_offset[i*LOG_LINE_OFFSET +: LOG_LINE_OFFSET];
        sel_wdata = req_wdata[i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef SRAM_ARB_RR_EN
  logic [IDX_W-1:0] ptr_nxt;

  // Pointer names the highest-priority requester for the next arbitration.
  always_comb begin
    ptr_nxt = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        ptr_nxt = (i == NREQ - 1) ? '0 : IDX_W'(i + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (|grant) begin
      ptr <= ptr_nxt;
    end
  end
`else
  assign ptr = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      owner     <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_off_q  <= '0;
      wr_data_q <= '0;
      we_q      <= 1'b0;
      rv_q      <= '0;
    end else begin
      we_q <= 1'b0;
      rv_q <= '0;
      case (state)
        IDLE: begin
          if (|grant) begin
            owner <= grant;
            if (sel_write) begin
              wr_addr_q <= sel_addr;
              wr_off_q  <= sel_off;
              wr_data_q <= sel_wdata;
              we_q      <= 1'b1;
              rv_q      <= grant;
              state     <= WRITE_ACK;
            end else begin
              rd_addr_q <= sel_addr;
              cnt       <= SRAM_ARB_CNT_W'(DELAY);
              state     <= READ_WAIT;
            end
          end
        end
        READ_WAIT: begin
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
            // Raise the pulse so it lines up with the cycle the counter reads zero.
            if (cnt == SRAM_ARB_CNT_W'(1)) begin
              rv_q <= owner;
            end
          end
        end
        WRITE_ACK: state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  assign req_ready         = grant;
  assign sram_read_addr    = (|grant) ? sel_addr : rd_addr_q;
  assign sram_write_addr   = wr_addr_q;
  assign sram_write_offset = wr_off_q;
  assign sram_write_data   = wr_data_q;
  // A reset landing mid-operation must suppress the pending write and response.
  assign sram_write_en     = we_q & ~reset;
  assign rsp_valid         = rv_q & {NREQ{~reset}};
  assign rsp_data          = sram_read_data;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - directed bench for sram_port_arbiter at DELAY 1, 3 and 15
module tb_sram_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst           [3];
  logic [1:0]  req_valid     [3];
  logic [1:0]  req_ready     [3];
  logic [1:0]  req_write     [3];
  logic [17:0] req_addr      [3];
  logic [5:0]  req_offset    [3];
  logic [31:0] req_wdata     [3];
  logic [1:0]  rsp_valid     [3];
  logic [15:0] rsp_data      [3];
  logic [8:0]  sram_read_addr  [3];
  logic [8:0]  sram_write_addr [3];
  logic [2:0]  sram_write_offset [3];
  logic [15:0] sram_write_data [3];
  logic        sram_write_en [3];

  logic [15:0] mem [512];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int D = (g == 0) ? 1 : (g == 1) ? 3 : 15;
    logic [8:0]  pipe [D];
    logic [15:0] rd;

    always @(posedge clk) begin
      pipe[0] <= sram_read_addr[g];
      for (int k = 1; k < D; k++) pipe[k] <= pipe[k-1];
    end
    assign rd = mem[pipe[D-1]];

    sram_port_arbiter #(
      .WIDTH(16), .LOG_DEPTH(9), .LOG_LINE_OFFSET(3), .NREQ(2), .DELAY(D)
    ) dut (
      .clk               (clk),
      .reset             (rst[g]),
      .req_valid         (req_valid[g]),
      .req_ready         (req_ready[g]),
      .req_write         (req_write[g]),
      .req_addr          (req_addr[g]),
      .req_offset        (req_offset[g]),
      .req_wdata         (req_wdata[g]),
      .rsp_valid         (rsp_valid[g]),
      .rsp_data          (rsp_data[g]),
      .sram_read_addr    (sram_read_addr[g]),
      .sram_write_addr   (sram_write_addr[g]),
      .sram_write_offset (sram_write_offset[g]),
      .sram_write_data   (sram_write_data[g]),
      .sram_write_en     (sram_write_en[g]),
      .sram_read_data    (rd)
    );
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [1:0] gr [4];
  int gcyc [4];
  int ngr, cyc;
  logic bad;
  logic [1:0] exp_gr [4];

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 16'h1000 + 16'(i);
    mem[5] = 16'hBEEF;
    for (int g = 0; g < 3; g++) begin
      rst[g] = 1'b1; req_valid[g] = 2'b11; req_write[g] = 2'b00;
      req_addr[g] = '0; req_offset[g] = '0; req_wdata[g] = '0;
    end

    // Reset: no grant, response or write even with requests pending
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", 32'(req_ready[0]), 32'h0);
    check("rst_rsp", 32'(rsp_valid[0]), 32'h0);
    check("rst_we", 32'(sram_write_en[0]), 32'h0);
    for (int g = 0; g < 3; g++) begin rst[g] = 1'b0; req_valid[g] = 2'b00; end
    @(negedge clk);

    // DELAY=1 read of addr 5 by requester 0
    req_addr[0] = {9'd0, 9'd5}; req_valid[0] = 2'b01; #1;
    check("a_ready", 32'(req_ready[0]), 32'h1);
    check("a_raddr", 32'(sram_read_addr[0]), 32'd5);
    @(negedge clk); #1;
    check("a_busy_ready", 32'(req_ready[0]), 32'h0);
    check("a_rsp_early", 32'(rsp_valid[0]), 32'h0);
    @(negedge clk); req_valid[0] = 2'b00; #1;
    check("a_rsp", 32'(rsp_valid[0]), 32'h1);
    check("a_data", 32'(rsp_data[0]), 32'hBEEF);
    @(negedge clk);

    // Requester 1 writes 0xAAAA at addr 3, offset 2
    req_addr[0] = {9'd3, 9'd0}; req_offset[0] = {3'd2, 3'd0};
    req_wdata[0] = {16'hAAAA, 16'h0}; req_write[0] = 2'b10; req_valid[0] = 2'b10; #1;
    check("b_ready", 32'(req_ready[0]), 32'h2);
    @(negedge clk); req_valid[0] = 2'b00; #1;
    check("b_we", 32'(sram_write_en[0]), 32'h1);
    check("b_waddr", 32'(sram_write_addr[0]), 32'd3);
    check("b_woff", 32'(sram_write_offset[0]), 32'd2);
    check("b_wdata", 32'(sram_write_data[0]), 32'hAAAA);
    check("b_rsp", 32'(rsp_valid[0]), 32'h2);
    @(negedge clk); #1;
    check("b_we_off", 32'(sram_write_en[0]), 32'h0);
    check("b_rsp_off", 32'(rsp_valid[0]), 32'h0);

    // Both requesters read continuously: record four grants
`ifdef SRAM_ARB_RR_EN
    exp_gr = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_gr = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    req_write[0] = 2'b00; req_addr[0] = {9'd2, 9'd1}; req_valid[0] = 2'b11;
    ngr = 0; cyc = 0;
    #1;
    while (ngr < 4 && cyc < 60) begin
      if (req_ready[0] != 2'b00) begin
        gr[ngr] = req_ready[0]; gcyc[ngr] = cyc; ngr++;
      end
      @(negedge clk); #1;
      cyc++;
    end
    req_valid[0] = 2'b00;
    check("c_count", 32'(ngr), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("c_grant%0d", i), 32'(gr[i]), 32'(exp_gr[i]));
    check("c_gap", 32'(gcyc[1] - gcyc[0]), 32'd3);
    repeat (4) @(negedge clk);

    // DELAY=3: reset in READ_WAIT abandons the read; pointer back at 0
    req_addr[1] = {9'd9, 9'd5}; req_valid[1] = 2'b01; #1;
    check("d_ready", 32'(req_ready[1]), 32'h1);
    @(negedge clk); req_valid[1] = 2'b00;
    @(negedge clk); rst[1] = 1'b1;
    @(negedge clk); rst[1] = 1'b0; req_valid[1] = 2'b11; #1;
    check("d_ready_after_rst", 32'(req_ready[1]), 32'h1);
    check("d_rsp_rst", 32'(rsp_valid[1]), 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); req_valid[1] = 2'b00; #1;
      check($sformatf("d_no_rsp%0d", k), 32'(rsp_valid[1]), 32'h0);
    end
    @(negedge clk); #1;
    check("d_rsp", 32'(rsp_valid[1]), 32'h1);
    check("d_data", 32'(rsp_data[1]), 32'hBEEF);

    // DELAY=15 read then immediate write from requester 1
    req_addr[2] = {9'd3, 9'd5}; req_write[2] = 2'b10; req_wdata[2] = {16'h1234, 16'h0};
    req_valid[2] = 2'b01; #1;
    check("e_ready", 32'(req_ready[2]), 32'h1);
    bad = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk); req_valid[2] = 2'b10; #1;
      if (req_ready[2] != 2'b00 || rsp_valid[2] != 2'b00) bad = 1'b1;
    end
    check("e_quiet", 32'(bad), 32'h0);
    @(negedge clk); #1;
    check("e_rsp", 32'(rsp_valid[2]), 32'h1);
    check("e_data", 32'(rsp_data[2]), 32'hBEEF);
    check("e_no_early_grant", 32'(req_ready[2]), 32'h0);
    @(negedge clk); #1;
    check("e_wr_grant", 32'(req_ready[2]), 32'h2);
    @(negedge clk); req_valid[2] = 2'b00; #1;
    check("e_we", 32'(sram_write_en[2]), 32'h1);
    check("e_wr_rsp", 32'(rsp_valid[2]), 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
